lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
- Two-requester arbiter sharing the single data port of the load/store memory: the core data path (m0) and a secondary master (m1, program loader / debug / DMA).
- Sits between the requesters and the memory/peripheral unit. Drives one address/write-data/write-enable set per cycle and returns read data to the owning master.
- Fair sharing is bounded round-robin. A master may hold the port for up to MAX_BURST consecutive grants while the other waits, then ownership must rotate.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- MAX_BURST, 4, max consecutive grants to one master while the other is requesting (>=1).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- m0_req_i  in  1  m0 access request; held until granted.
- m0_we_i  in  1  m0 write (1) / read (0).
- m0_addr_i  in  ADDR_W  m0 word address.
- m0_wdata_i  in  DATA_W  m0 write data.
- m0_gnt_o  out  1  m0 access accepted this cycle.
- m0_rvalid_o  out  1  m0 read data valid (one cycle after a read grant).
- m0_rdata_o  out  DATA_W  m0 read data.
- m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_gnt_o, m1_rvalid_o, m1_rdata_o: same as m0, for m1.
- mem_addr_o  out  ADDR_W  address to memory.
- mem_wdata_o  out  DATA_W  write data to memory.
- mem_we_o  out  1  write enable to memory; memory writes on the clock edge.
- mem_rdata_i  in  DATA_W  combinational read data from memory.
- busy_o  out  1  a grant is issued this cycle.

Behaviour:
- State registers:
  - owner: NONE, M0 or M1 = last granted master.
  - burst_cnt: 0..MAX_BURST = consecutive grants to owner.
  - rsel: which master gets pending read data.
  - rvalid register and rdata register.
- Grant, combinational within the cycle:
  - Neither requests: no grant.
  - Only one requests: grant it.
  - Both request, owner==M0 or M1, and burst_cnt<MAX_BURST: grant owner.
  - Both request, otherwise: grant the non-owner.
  - Both request, owner==NONE: grant m0.
- Exactly one gnt_o is high at most. busy_o = m0_gnt_o | m1_gnt_o.
- Memory port:
  - mem_addr_o/mem_wdata_o = granted master's inputs. If no grant, they hold m0's inputs.
  - mem_we_o = granted master's we_i & grant; 0 when no grant.
- Counter update at the clock edge:
  - Grant to the same master as owner: burst_cnt = min(burst_cnt+1, MAX_BURST), saturating.
  - Grant to a different master: owner = new master, burst_cnt = 1.
  - No grant: owner unchanged, burst_cnt = 0.
  - A lone requester is never blocked by the limit. Saturation only matters when both request.
- Read return, one cycle of latency:
  - On a read grant, the rdata register captures mem_rdata_i at the edge and rsel = granted master.
  - Next cycle: the selected mX_rvalid_o = 1 and mX_rdata_o = the rdata register.
  - Write grants produce no rvalid.
  - The non-selected master's rdata_o = 0 and rvalid_o = 0.
  - Back-to-back reads give rvalid every cycle.
- Reset (rst_i=1 at an edge):
  - owner=NONE, burst_cnt=0, rvalid=0, rdata=0.
  - While rst_i=1, all gnt_o=0, mem_we_o=0 and busy_o=0, with combinational gating.
  - A read granted in the cycle before reset produces no rvalid; the pending return is dropped.
- Simultaneous events:
  - A request deasserting in the same cycle it would win is simply not granted.
  - A master may issue a new request in the same cycle its previous rvalid is delivered.
- MAX_BURST=1 gives strict alternation under continuous contention.

Test Plan:
- Reset, then m0 reads addr 5 (mem holds 0xDEAD_BEEF) -> m0_gnt_o=1 same cycle, next cycle m0_rvalid_o=1, m0_rdata_o=0xDEADBEEF, m1_rvalid_o=0.
- Both request continuously from reset, MAX_BURST=4 -> grant sequence M0,M0,M0,M0,M1,M1,M1,M1,M0...; never more than 4 consecutive grants to one master.
- Only m1 requests for 10 cycles -> m1 granted all 10 cycles; burst_cnt saturates at 4 and does not block.
- m0 writes 0x0000_00FF to addr 256 while m1 idle -> mem_we_o=1, mem_addr_o=256, mem_wdata_o=0xFF for exactly one cycle; no rvalid.
- m1 read granted in cycle N, rst_i=1 in cycle N+1 -> m1_rvalid_o=0 in N+1 and after; owner=NONE; first tie after reset goes to m0.
- MAX_BURST=1, both issuing reads to addrs 0 (m0) and 1 (m1) -> grants alternate M0,M1,M0...; each master's rvalid arrives one cycle after its grant, with matching data.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Two-master arbiter for the load/store memory data port: bounded round-robin
// grant, single shared address/data/we port, one-cycle read return to the owner.
module lsu_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [DATA_W-1:0] m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [DATA_W-1:0] m1_rdata_o,

    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    input  logic [DATA_W-1:0] mem_rdata_i,

    output logic              busy_o
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;

    logic [1:0]        owner_q;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic              rvalid_q;
    logic              rsel_q;
    logic [DATA_W-1:0] rdata_q;

    logic              gnt0;
    logic              gnt1;
    logic              at_limit;
    logic              read_gnt;
    logic [1:0]        gnt_owner;

    assign at_limit = (burst_cnt_q >= CNT_MAX);

    // NOTE: both grants get a default before any branch so no latch is inferred.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i) begin
            if (m0_req_i && m1_req_i) begin
                if (owner_q == OWN_M0) begin
                    gnt0 = !at_limit;
                    gnt1 = at_limit;
                end else if (owner_q == OWN_M1) begin
                    gnt1 = !at_limit;
                    gnt0 = at_limit;
                end else begin
                    gnt0 = 1'b1;
                end
            end else begin
                gnt0 = m0_req_i;
                gnt1 = m1_req_i;
            end
        end
    end

    assign m0_gnt_o    = gnt0;
    assign m1_gnt_o    = gnt1;
    assign busy_o      = gnt0 | gnt1;

    // With no grant the port idles on m0's inputs.
    assign mem_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
    assign mem_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;
    assign mem_we_o    = (gnt1 & m1_we_i) | (gnt0 & m0_we_i);

    assign read_gnt    = busy_o & ~mem_we_o;
    assign gnt_owner   = gnt1 ? OWN_M1 : OWN_M0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q     <= OWN_NONE;
            burst_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            rsel_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (busy_o) begin
                if (gnt_owner == owner_q) begin
                    if (!at_limit) begin
                        burst_cnt_q <= burst_cnt_q + CNT_W'(1);
                    end
                end else begin
                    owner_q     <= gnt_owner;
                    burst_cnt_q <= CNT_W'(1);
                end
            end else begin
                burst_cnt_q <= '0;
            end

            rvalid_q <= read_gnt;
            if (read_gnt) begin
                rdata_q <= mem_rdata_i;
                rsel_q  <= gnt1;
            end
        end
    end

    // Reset masks a return still pending from the cycle before it.
    assign m0_rvalid_o = rvalid_q & ~rsel_q & ~rst_i;
    assign m1_rvalid_o = rvalid_q &  rsel_q & ~rst_i;
    assign m0_rdata_o  = m0_rvalid_o ? rdata_q : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: MAX_BURST=4 instance "a" on a small memory
// model, MAX_BURST=1 instance "b" on a pattern memory; reads are scoreboarded.
module tb_lsu_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- instance a (MAX_BURST = 4) ----------------
    logic        a_rst;
    logic        a_m0_req, a_m0_we, a_m0_gnt, a_m0_rvalid;
    logic [31:0] a_m0_addr, a_m0_wdata, a_m0_rdata;
    logic        a_m1_req, a_m1_we, a_m1_gnt, a_m1_rvalid;
    logic [31:0] a_m1_addr, a_m1_wdata, a_m1_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_mem_we, a_busy;

    lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) u_a (
        .clk_i(clk), .rst_i(a_rst),
        .m0_req_i(a_m0_req), .m0_we_i(a_m0_we), .m0_addr_i(a_m0_addr),
        .m0_wdata_i(a_m0_wdata), .m0_gnt_o(a_m0_gnt), .m0_rvalid_o(a_m0_rvalid),
        .m0_rdata_o(a_m0_rdata),
        .m1_req_i(a_m1_req), .m1_we_i(a_m1_we), .m1_addr_i(a_m1_addr),
        .m1_wdata_i(a_m1_wdata), .m1_gnt_o(a_m1_gnt), .m1_rvalid_o(a_m1_rvalid),
        .m1_rdata_o(a_m1_rdata),
        .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_we_o(a_mem_we),
        .mem_rdata_i(a_mem_rdata), .busy_o(a_busy)
    );

    logic [31:0] a_mem [0:511];
    always @(posedge clk) begin
        if (a_rst) begin
            for (int i = 0; i < 512; i++) a_mem[i] <= 32'h0;
            a_mem[5] <= 32'hDEAD_BEEF;
        end else if (a_mem_we) begin
            a_mem[a_mem_addr[8:0]] <= a_mem_wdata;
        end
    end
    assign a_mem_rdata = a_mem[a_mem_addr[8:0]];

    // ---------------- instance b (MAX_BURST = 1) ----------------
    logic        b_rst;
    logic        b_m0_req, b_m0_we, b_m0_gnt, b_m0_rvalid;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata;
    logic        b_m1_req, b_m1_we, b_m1_gnt, b_m1_rvalid;
    logic [31:0] b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_we, b_busy;

    lsu_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) u_b (
        .clk_i(clk), .rst_i(b_rst),
        .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr),
        .m0_wdata_i(b_m0_wdata), .m0_gnt_o(b_m0_gnt), .m0_rvalid_o(b_m0_rvalid),
        .m0_rdata_o(b_m0_rdata),
        .m1_req_i(b_m1_req), .m1_we_i(b_m1_we), .m1_addr_i(b_m1_addr),
        .m1_wdata_i(b_m1_wdata), .m1_gnt_o(b_m1_gnt), .m1_rvalid_o(b_m1_rvalid),
        .m1_rdata_o(b_m1_rdata),
        .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_we_o(b_mem_we),
        .mem_rdata_i(b_mem_rdata), .busy_o(b_busy)
    );

    assign b_mem_rdata = {16'hC0DE, b_mem_addr[15:0]};

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] q_a0[$], q_a1[$], q_b0[$], q_b1[$];

    always @(negedge clk) begin
        if (a_m0_rvalid) begin
            if (q_a0.size() == 0) chk("a_m0 unexpected rvalid", 1, 0);
            else chk("a_m0 rdata", a_m0_rdata, q_a0.pop_front());
            chk("a_m1 idle rdata", a_m1_rdata, 0);
        end
        if (a_m1_rvalid) begin
            if (q_a1.size() == 0) chk("a_m1 unexpected rvalid", 1, 0);
            else chk("a_m1 rdata", a_m1_rdata, q_a1.pop_front());
            chk("a_m0 idle rdata", a_m0_rdata, 0);
        end
        if (b_m0_rvalid) begin
            if (q_b0.size() == 0) chk("b_m0 unexpected rvalid", 1, 0);
            else chk("b_m0 rdata", b_m0_rdata, q_b0.pop_front());
        end
        if (b_m1_rvalid) begin
            if (q_b1.size() == 0) chk("b_m1 unexpected rvalid", 1, 0);
            else chk("b_m1 rdata", b_m1_rdata, q_b1.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_m0;
        logic prev_m0;

        a_rst = 1'b1; b_rst = 1'b1;
        a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = '0; a_m0_wdata = '0;
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = '0; a_m1_wdata = '0;
        b_m0_req = 1'b0; b_m0_we = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;

        // Requests asserted while in reset must be gated off.
        step(); step();
        @(negedge clk);
        chk("rst m0_gnt", a_m0_gnt, 0);
        chk("rst m1_gnt", a_m1_gnt, 0);
        chk("rst busy", a_busy, 0);
        chk("rst mem_we", a_mem_we, 0);
        chk("rst m0_rvalid", a_m0_rvalid, 0);

        // Single m0 read of addr 5.
        step();
        a_rst = 1'b0;
        a_m1_req = 1'b0;
        a_m0_req = 1'b1; a_m0_we = 1'b0; a_m0_addr = 32'd5;
        q_a0.push_back(32'hDEAD_BEEF);
        @(negedge clk);
        chk("rd m0_gnt", a_m0_gnt, 1);
        chk("rd m1_gnt", a_m1_gnt, 0);
        chk("rd mem_addr", a_mem_addr, 32'd5);
        chk("rd mem_we", a_mem_we, 0);
        step();
        a_m0_req = 1'b0;
        @(negedge clk);
        chk("rd m0_rvalid", a_m0_rvalid, 1);
        chk("rd m1_rvalid", a_m1_rvalid, 0);
        chk("rd idle busy", a_busy, 0);

        // Continuous contention from reset: four grants each, rotating.
        step();
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
        a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 32'd100; a_m0_wdata = 32'h1;
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'd101; a_m1_wdata = 32'h2;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step();
            exp_m0 = ((i / 4) % 2) == 0;
            @(negedge clk);
            chk($sformatf("burst4 m0_gnt[%0d]", i), a_m0_gnt, exp_m0);
            chk($sformatf("burst4 m1_gnt[%0d]", i), a_m1_gnt, !exp_m0);
            chk($sformatf("burst4 addr[%0d]", i), a_mem_addr, exp_m0 ? 32'd100 : 32'd101);
        end

        // Lone m1 reads for 10 cycles: the burst limit never blocks it.
        step();
        a_m0_req = 1'b0;
        a_m1_we = 1'b0; a_m1_addr = 32'd5;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            q_a1.push_back(32'hDEAD_BEEF);
            @(negedge clk);
            chk($sformatf("lone m1_gnt[%0d]", i), a_m1_gnt, 1);
        end

        // Saturated m1 yields to m0 on the next tie.
        step();
        a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 32'd300;
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'd301;
        @(negedge clk);
        chk("sat tie m0_gnt", a_m0_gnt, 1);

        // m0 single write of 0xFF to 256.
        step();
        a_m1_req = 1'b0;
        a_m0_addr = 32'd256; a_m0_wdata = 32'h0000_00FF;
        @(negedge clk);
        chk("wr mem_we", a_mem_we, 1);
        chk("wr mem_addr", a_mem_addr, 32'd256);
        chk("wr mem_wdata", a_mem_wdata, 32'h0000_00FF);
        step();
        a_m0_req = 1'b0;
        @(negedge clk);
        chk("wr after mem_we", a_mem_we, 0);
        chk("wr no rvalid", a_m0_rvalid, 0);
        step();
        a_m0_req = 1'b1; a_m0_we = 1'b0;
        q_a0.push_back(32'h0000_00FF);
        @(negedge clk);
        chk("rdback m0_gnt", a_m0_gnt, 1);

        // m1 read granted, then reset in the following cycle drops its return.
        step();
        a_m0_req = 1'b0;
        a_m1_req = 1'b1; a_m1_we = 1'b0; a_m1_addr = 32'd5;
        @(negedge clk);
        chk("pre-rst m1_gnt", a_m1_gnt, 1);
        step();
        a_m1_req = 1'b0;
        a_rst = 1'b1;
        @(negedge clk);
        chk("rst drop m1_rvalid", a_m1_rvalid, 0);
        chk("rst drop busy", a_busy, 0);
        step();
        a_rst = 1'b0;
        a_m0_req = 1'b1; a_m0_we = 1'b1; a_m0_addr = 32'd400;
        a_m1_req = 1'b1; a_m1_we = 1'b1; a_m1_addr = 32'd401;
        @(negedge clk);
        chk("post-rst m1_rvalid", a_m1_rvalid, 0);
        chk("post-rst tie m0_gnt", a_m0_gnt, 1);
        chk("post-rst tie m1_gnt", a_m1_gnt, 0);
        step();
        a_m0_req = 1'b0; a_m1_req = 1'b0;

        // MAX_BURST=1: strict alternation of reads, data one cycle later.
        b_rst = 1'b0;
        b_m0_req = 1'b1; b_m0_we = 1'b0; b_m0_addr = 32'd0;
        b_m1_req = 1'b1; b_m1_we = 1'b0; b_m1_addr = 32'd1;
        prev_m0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step();
            exp_m0 = (i % 2) == 0;
            if (exp_m0) q_b0.push_back(32'hC0DE_0000);
            else        q_b1.push_back(32'hC0DE_0001);
            @(negedge clk);
            chk($sformatf("alt m0_gnt[%0d]", i), b_m0_gnt, exp_m0);
            chk($sformatf("alt m1_gnt[%0d]", i), b_m1_gnt, !exp_m0);
            if (i > 0) begin
                chk($sformatf("alt rvalid[%0d]", i), prev_m0 ? b_m0_rvalid : b_m1_rvalid, 1);
            end
            prev_m0 = exp_m0;
        end
        step();
        b_m0_req = 1'b0; b_m1_req = 1'b0;
        @(negedge clk);
        chk("alt last rvalid", prev_m0 ? b_m0_rvalid : b_m1_rvalid, 1);
        step();
        step();
        @(negedge clk);

        chk("q_a0 drained", q_a0.size(), 0);
        chk("q_a1 drained", q_a1.size(), 0);
        chk("q_b0 drained", q_b0.size(), 0);
        chk("q_b1 drained", q_b1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
